// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register map and status bit positions shared by the UART
// memory-mapped register block and its RX buffer.
package uart_mmio_pkg;

  // CPU byte addresses of the UART registers (bits [1:0] are never decoded)
  localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
  localparam logic [31:0] UART_RX_ADDR   = 32'h8000_0004;
  localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;
  localparam logic [31:0] CYCLE_CNT_ADDR = 32'h8000_0010;
  localparam logic [31:0] CYCLE_RST_ADDR = 32'h8000_0018;

  // Bit positions inside the status word
  localparam int STATUS_TX_FREE_BIT     = 0;
  localparam int STATUS_RX_NONEMPTY_BIT = 1;

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO used as the UART receive buffer.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without an occupancy counter. Push on full and pop on empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Advance each pointer by one on an accepted push / pop; wrap is natural
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  // Pointer registers; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because empty hides them
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: CPU-side UART register block. Decodes loads/stores in the
// 0x8000_0000 window, buffers received bytes in a sync_fifo and holds one
// transmit byte until the UART transmitter takes it.
// Optional feature macro: UART_MMIO_CYCLE_COUNTER_EN adds a 32-bit
// free-running cycle counter (read 0x8000_0010, clear by store 0x8000_0018).
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic [7:0]  data_out,
  input  logic        data_out_valid,
  output logic        data_out_ready,
  output logic [7:0]  data_in,
  output logic        data_in_valid,
  input  logic        data_in_ready
);

  logic [29:0] word;
  logic        hit_ctrl, hit_rx, hit_tx, hit_cnt;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic        rx_push, rx_pop;
  logic        tx_accept;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cyc_val;
  logic        unused_bits;

  // Byte-lane bits of the address and upper store data carry no meaning here
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  assign word     = addr[31:2];
  assign hit_ctrl = (word == UART_CTRL_ADDR[31:2]);
  assign hit_rx   = (word == UART_RX_ADDR[31:2]);
  assign hit_tx   = (word == UART_TX_ADDR[31:2]);
  assign hit_cnt  = (word == CYCLE_CNT_ADDR[31:2]);

  assign data_out_ready = !fifo_full;
  assign rx_push        = data_out_valid && data_out_ready;
  // The FIFO itself ignores a pop while empty, so an empty read pops nothing
  assign rx_pop         = re && hit_rx;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (data_out),
    .pop       (rx_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

`ifdef UART_MMIO_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;
  logic        hit_crst;

  assign hit_crst = (word == CYCLE_RST_ADDR[31:2]);
  assign cyc_val  = cyc_q;

  // Free-running counter; any store to the clear address restarts it at 0
  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (we && hit_crst) cyc_d = '0;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end
`else
  assign cyc_val = '0;
`endif

  // A store is taken only when the holding register was already empty before
  // this edge; a handshake completing on the same edge does not free it early
  assign tx_accept = we && hit_tx && !tx_full_q;

  // TX holding register: load on accepted store, clear on transmitter handshake
  always_comb begin
    tx_full_d = tx_full_q;
    tx_byte_d = tx_byte_q;
    if (tx_accept) begin
      tx_full_d = 1'b1;
      tx_byte_d = wdata[7:0];
    end else if (tx_full_q && data_in_ready) begin
      tx_full_d = 1'b0;
    end
  end

  // Load data: sampled from pre-edge state on re, held otherwise
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = '0;
      if (hit_ctrl) begin
        rdata_d[STATUS_TX_FREE_BIT]     = !tx_full_q;
        rdata_d[STATUS_RX_NONEMPTY_BIT] = !fifo_empty;
      end else if (hit_rx) begin
        if (!fifo_empty) rdata_d[7:0] = fifo_head;
      end else if (hit_cnt) begin
        rdata_d = cyc_val;
      end
    end
  end

  // TX and load-data registers; reset discards any pending transmit byte
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_full_q <= 1'b0;
      tx_byte_q <= '0;
      rdata_q   <= '0;
    end else begin
      tx_full_q <= tx_full_d;
      tx_byte_q <= tx_byte_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_in_valid = tx_full_q;
  assign data_in       = tx_byte_q;
  assign rdata         = rdata_q;

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio. The driver applies directed
// and random traffic and keeps a queue-based model of the register map; load
// results and transmitted bytes are checked by a separate monitor process.
module tb_uart_mmio;

  localparam int RX_DEPTH = 4;
  localparam logic [31:0] A_CTRL = 32'h8000_0000;
  localparam logic [31:0] A_RX   = 32'h8000_0004;
  localparam logic [31:0] A_TX   = 32'h8000_0008;
  localparam logic [31:0] A_CNT  = 32'h8000_0010;
  localparam logic [31:0] A_CRST = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  data_out = '0;
  logic        data_out_valid = 1'b0;
  logic        data_out_ready;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_in_ready = 1'b0;

  always #5 clk = ~clk;

  uart_mmio #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .wdata          (wdata),
    .we             (we),
    .re             (re),
    .rdata          (rdata),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready)
  );

  int vectors = 0;
  int miscompares = 0;
  int tx_xfers = 0;

  // Scoreboard queues and reference model state
  logic [31:0] exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  m_rx[$];
  bit          m_tx_pend = 1'b0;
  logic [7:0]  m_tx_byte = '0;
  logic [31:0] m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge worth of the current inputs to the model
  task automatic model_edge(output bit acc);
    logic [31:0] w;
    logic [31:0] rv;
    int          pre;
    bit          accept;
    w   = {addr[31:2], 2'b00};
    rv  = '0;
    pre = m_rx.size();
    acc = data_out_valid && (pre < RX_DEPTH);
    if (re) begin
      if (w == A_CTRL) rv = {30'b0, pre != 0, !m_tx_pend};
      else if (w == A_RX && pre != 0) rv = {24'b0, m_rx.pop_front()};
`ifdef UART_MMIO_CYCLE_COUNTER_EN
      else if (w == A_CNT) rv = m_cnt;
`endif
      exp_rd_q.push_back(rv);
    end
    if (acc) m_rx.push_back(data_out);
    accept = we && (w == A_TX) && !m_tx_pend;
    if (accept) begin
      m_tx_pend = 1'b1;
      m_tx_byte = wdata[7:0];
      exp_tx_q.push_back(wdata[7:0]);
    end else if (m_tx_pend && data_in_ready) begin
      m_tx_pend = 1'b0;
    end
    if (we && w == A_CRST) m_cnt = '0;
    else m_cnt = m_cnt + 32'd1;
  endtask

  task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input bit v, input logic [7:0] b, input bit ir, output bit acc);
    re = r; we = w; addr = a; wdata = wd;
    data_out_valid = v; data_out = b; data_in_ready = ir;
    @(negedge clk);
    chk("data_out_ready", 32'(data_out_ready), 32'(m_rx.size() < RX_DEPTH));
    chk("data_in_valid", 32'(data_in_valid), 32'(m_tx_pend));
    chk("data_in", 32'(data_in), 32'(m_tx_byte));
    model_edge(acc);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit ir);
    bit a;
    repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, ir, a);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    data_out_valid = 1'b0; data_out = '0; data_in_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    m_rx.delete();
    exp_tx_q.delete();
    m_tx_pend = 1'b0;
    m_tx_byte = '0;
    m_cnt     = '0;
    chk("rdata_after_reset", rdata, 32'h0);
  endtask

  // Monitor: compare load data the cycle after re, and every transmit handshake
  logic        re_seen = 1'b0;
  logic [31:0] last_rd = '0;
  always @(posedge clk) re_seen <= re && !rst;

  always @(negedge clk) begin
    if (rst) begin
      last_rd = '0;
    end else begin
      if (re_seen) begin
        if (exp_rd_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rdata_unexpected: got 0x%08h, expected no load result", rdata);
        end else begin
          last_rd = exp_rd_q.pop_front();
          chk("rdata", rdata, last_rd);
        end
      end else begin
        chk("rdata_hold", rdata, last_rd);
      end
      if (data_in_valid && data_in_ready) begin
        tx_xfers++;
        if (exp_tx_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL tx_unexpected: got byte 0x%02h, expected no transfer", data_in);
        end else begin
          chk("tx_byte", 32'(data_in), 32'(exp_tx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic logic [31:0] pick_addr();
    logic [31:0] offs;
    if ($urandom_range(0, 9) == 0) return $urandom;
    offs = 32'($urandom_range(0, 7)) << 2;
    return A_CTRL + offs + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    bit          acc;
    bit          got5;
    bit          hv;
    logic [7:0]  hb;
    logic [7:0]  echo_b;
    int          x0;

    do_reset(3);

    // Status after reset
    step(1, 0, A_CTRL, 0, 0, 8'h00, 0, acc);
    idle(1, 0);

    // Single received byte, status / data / status
    step(0, 0, 0, 0, 1, 8'h5A, 0, acc);
    step(1, 0, A_CTRL, 0, 0, 8'h00, 0, acc);
    step(1, 0, A_RX, 0, 0, 8'h00, 0, acc);
    step(1, 0, A_CTRL, 0, 0, 8'h00, 0, acc);
    idle(1, 0);

    // Fill the FIFO, hold a fifth byte under backpressure, drain it
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 0, 1, 8'(k), 0, acc);
    step(0, 0, 0, 0, 1, 8'h05, 0, acc);
    got5 = acc;
    for (int k = 0; k < 6; k++) begin
      step(1, 0, A_RX, 0, !got5, 8'h05, 0, acc);
      if (acc) got5 = 1'b1;
    end
    idle(1, 0);

    // Transmit holding register, dropped store while full, single transfer
    x0 = tx_xfers;
    step(0, 1, A_TX, 32'h0000_0041, 0, 8'h00, 0, acc);
    idle(2, 0);
    step(1, 0, A_CTRL, 0, 0, 8'h00, 0, acc);
    step(0, 1, A_TX, 32'hFFFF_FF42, 0, 8'h00, 0, acc);
    idle(1, 0);
    idle(3, 1);
    chk("tx_single_transfer", 32'(tx_xfers - x0), 32'd1);

    // Store on the same edge a handshake completes is dropped
    step(0, 1, A_TX, 32'h44, 0, 8'h00, 0, acc);
    step(0, 1, A_TX, 32'h45, 0, 8'h00, 1, acc);
    idle(3, 1);

    // Echo loop: host byte, CPU polls status, loads, stores it back
    x0 = tx_xfers;
    step(0, 0, 0, 0, 1, 8'h3C, 1, acc);
    for (int k = 0; k < 10; k++) begin
      step(1, 0, A_CTRL, 0, 0, 8'h00, 1, acc);
      if (rdata[1]) break;
    end
    step(1, 0, A_RX, 0, 0, 8'h00, 1, acc);
    echo_b = rdata[7:0];
    step(0, 1, A_TX, {24'h0, echo_b}, 0, 8'h00, 1, acc);
    idle(4, 1);
    chk("echo_transfer_count", 32'(tx_xfers - x0), 32'd1);

    // Cycle counter clear then read ten cycles later
    step(0, 1, A_CRST, 32'h0, 0, 8'h00, 0, acc);
    idle(9, 0);
    step(1, 0, A_CNT, 0, 0, 8'h00, 0, acc);
    idle(1, 0);

    // Reset while a TX byte is pending and the FIFO holds data
    step(0, 1, A_TX, 32'h77, 1, 8'h99, 0, acc);
    idle(1, 0);
    do_reset(1);
    idle(2, 0);

    // Randomized traffic
    hv = 1'b0;
    hb = '0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        idle(1, 0);
        do_reset(2);
        hv = 1'b0;
      end
      if (!hv && $urandom_range(0, 9) < 4) begin
        hv = 1'b1;
        hb = 8'($urandom);
      end
      step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, pick_addr(), $urandom,
           hv, hb, 1'($urandom_range(0, 1)), acc);
      if (acc) hv = 1'b0;
    end

    idle(4, 1);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
